// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential signed multiplier among NREQ requesters.
// Latches the winner's operands, sequences start/done, and returns the product with a one-cycle ack.
module mult_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   a_in,
    input  logic [NREQ*N-1:0]   b_in,
    output logic [NREQ-1:0]     ack,
    output logic [2*N-1:0]      result,
    output logic                err,
    output logic                busy,
    output logic                mul_start,
    output logic [N-1:0]        mul_mcand,
    output logic [N-1:0]        mul_mplier,
    input  logic [2*N-1:0]      mul_product,
    input  logic                mul_done
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [2*N-1:0]   result_q, result_d;
    logic             err_q, err_d;

    logic [IW-1:0]    sel_idx;
    logic [N-1:0]     a_sel;
    logic [N-1:0]     b_sel;
    int               pos;

    // Scan from the highest offset down so the first high request after ptr wins.
    always_comb begin
        sel_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        pos     = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            pos = int'(ptr_q) + k;
            if (pos >= int'(NREQ)) begin
                pos = pos - int'(NREQ);
            end
            if (req[IW'(pos)]) begin
                sel_idx = IW'(pos);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (sel_idx == IW'(i)) begin
                a_sel = a_in[i*N +: N];
                b_sel = b_in[i*N +: N];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d    = sel_idx;
                    mcand_d  = a_sel;
                    mplier_d = b_sel;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                done_d = mul_done;
                cnt_d  = cnt_q + 1'b1;
                // A rising edge in the first WAIT cycle may be left over from the previous op.
                if (mul_done && !done_q && (cnt_q != '0)) begin
                    result_d = mul_product;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else if (cnt_q == CntMax) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == StResp) begin
            ack[gnt_q] = 1'b1;
        end
    end

    assign busy       = (state_q != StIdle);
    assign mul_start  = (state_q == StIssue);
    assign mul_mcand  = mcand_q;
    assign mul_mplier = mplier_q;
    assign result     = result_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            gnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: a round-robin reference model predicts each grant,
// its product/err and its ack cycle; a monitor pops and compares whenever start or ack appears.
module tb_mult_share_arbiter;

    localparam int NREQ    = 4;
    localparam int N       = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        int             gnt;
        logic [2*N-1:0] res;
        logic           err;
        int             cyc;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
    } exp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } st_t;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*N-1:0]   a_in;
    logic [NREQ*N-1:0]   b_in;
    logic [NREQ-1:0]     ack;
    logic [2*N-1:0]      result;
    logic                err;
    logic                busy;
    logic                mul_start;
    logic [N-1:0]        mul_mcand;
    logic [N-1:0]        mul_mplier;
    logic [2*N-1:0]      mul_product;
    logic                mul_done;

    mult_share_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_mcand  (mul_mcand),
        .mul_mplier (mul_mplier),
        .mul_product(mul_product),
        .mul_done   (mul_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    st_t  st_q[$];

    logic [N-1:0] a_op [NREQ];
    logic [N-1:0] b_op [NREQ];
    int           rearm [NREQ];
    logic         rand_en;
    logic         force_stuck;
    int           force_lat;

    int   cyc          = 0;
    int   m_ptr        = 0;
    int   m_gnt        = 0;
    logic m_inflight   = 1'b0;
    int   m_arb_cyc    = -1;
    int   n_arb        = 0;
    int   last_ack_cyc = -1;

    int   op_lat;
    logic op_stuck;
    logic op_level;
    logic op_glitch;

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Behavioural sequential multiplier: done after op_lat cycles, optionally stuck,
    // level/pulse done, or with a spurious done in the first WAIT cycle.
    int             mb_cnt;
    logic           mb_busy;
    logic           mb_stuck;
    logic           mb_level;
    logic [N-1:0]   mb_a;
    logic [N-1:0]   mb_b;

    always @(posedge clk) begin
        if (rst) begin
            mul_done    <= 1'b0;
            mul_product <= '0;
            mb_busy     <= 1'b0;
            mb_cnt      <= 0;
            mb_stuck    <= 1'b0;
            mb_level    <= 1'b0;
        end else if (mul_start) begin
            mb_busy  <= 1'b1;
            mb_cnt   <= op_lat;
            mb_stuck <= op_stuck;
            mb_level <= op_level;
            mb_a     <= mul_mcand;
            mb_b     <= mul_mplier;
            if (op_glitch) begin
                mul_done    <= 1'b1;
                mul_product <= {mul_mplier, mul_mcand} ^ 32'h5A5A_A5A5;
            end else begin
                mul_done <= 1'b0;
            end
        end else if (mb_busy) begin
            if (mb_cnt == 1 && !mb_stuck) begin
                mul_done    <= 1'b1;
                mul_product <= smul(mb_a, mb_b);
                mb_busy     <= 1'b0;
            end else begin
                mul_done <= 1'b0;
                mb_cnt   <= mb_cnt - 1;
            end
        end else if (!mb_level) begin
            mul_done <= 1'b0;
        end
    end

    // Reference model: one op at a time, next arbitration one idle cycle after the ack.
    initial begin
        int   w;
        int   idx;
        exp_t e;
        st_t  s;
        op_lat    = 4;
        op_stuck  = 1'b0;
        op_level  = 1'b0;
        op_glitch = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_ptr      = 0;
                m_inflight = 1'b0;
                exp_q.delete();
                st_q.delete();
            end else if (req != '0 &&
                         (!m_inflight ||
                          (last_ack_cyc > m_arb_cyc && cyc >= last_ack_cyc + 2))) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (req[idx] && w < 0) w = idx;
                end
                op_lat    = (force_lat != 0) ? force_lat : int'($urandom_range(1, 20));
                op_stuck  = force_stuck || (rand_en && $urandom_range(0, 15) == 0);
                op_level  = ($urandom_range(0, 1) == 1);
                op_glitch = rand_en && ($urandom_range(0, 3) == 0);
                if (op_glitch && op_lat < 2) op_lat = 2;
                e.gnt = w;
                e.err = op_stuck;
                e.res = op_stuck ? '0 : smul(a_op[w], b_op[w]);
                e.cyc = op_stuck ? cyc + 1 + TIMEOUT : cyc + 2 + op_lat;
                e.a   = a_op[w];
                e.b   = b_op[w];
                exp_q.push_back(e);
                s.cyc = cyc;
                s.a   = a_op[w];
                s.b   = b_op[w];
                st_q.push_back(s);
                m_ptr      = (w + 1) % NREQ;
                m_gnt      = w;
                m_inflight = 1'b1;
                m_arb_cyc  = cyc;
                n_arb++;
            end
        end
    end

    // Monitor: compares every start and every ack against the scoreboard.
    initial begin
        exp_t           e;
        st_t            s;
        logic [NREQ-1:0] want_ack;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mul_start) begin
                    if (st_q.size() == 0) begin
                        chk("start_unexpected", 64'(mul_start), 64'd0);
                    end else begin
                        s = st_q.pop_front();
                        chk("start_cycle", 64'(cyc), 64'(s.cyc));
                        chk("start_mcand", 64'(mul_mcand), 64'(s.a));
                        chk("start_mplier", 64'(mul_mplier), 64'(s.b));
                        chk("start_busy", 64'(busy), 64'd1);
                    end
                end
                if (ack != '0) begin
                    last_ack_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", 64'(ack), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        want_ack = '0;
                        want_ack[e.gnt] = 1'b1;
                        chk("ack_onehot", 64'(ack), 64'(want_ack));
                        chk("ack_result", 64'(result), 64'(e.res));
                        chk("ack_err", 64'(err), 64'(e.err));
                        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                        chk("ack_mcand_hold", 64'(mul_mcand), 64'(e.a));
                        chk("ack_mplier_hold", 64'(mul_mplier), 64'(e.b));
                    end
                end
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            a_in[i*N +: N] = a_op[i];
            b_in[i*N +: N] = b_op[i];
        end
    endtask

    task automatic raise(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_op[i] = a;
        b_op[i] = b;
        req[i]  = 1'b1;
        pack();
    endtask

    function automatic logic [N-1:0] rand_operand();
        logic [N-1:0] t;
        case ($urandom_range(0, 7))
            0: t = 16'h8000;
            1: t = 16'h7FFF;
            2: t = 16'hFFFF;
            3: t = 16'h0000;
            default: t = N'($urandom);
        endcase
        return t;
    endfunction

    // Requesters: drop (or re-arm) on ack, and in random mode raise and occasionally
    // withdraw an already granted request.
    task automatic tick();
        logic busy_op;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                if (rearm[i] > 0) rearm[i]--;
                else req[i] = 1'b0;
            end
        end
        busy_op = m_inflight && (last_ack_cyc < m_arb_cyc) && (ack == '0);
        if (rand_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !(busy_op && m_gnt == i) && $urandom_range(0, 7) == 0) begin
                    raise(i, rand_operand(), rand_operand());
                end
            end
            if (busy_op && req[m_gnt] && $urandom_range(0, 15) == 0) req[m_gnt] = 1'b0;
        end
        pack();
    endtask

    task automatic check_reset_outputs();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mcand", 64'(mul_mcand), 64'd0);
        chk("rst_mplier", 64'(mul_mplier), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req != '0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n >= budget), 64'd0);
        tick();
        tick();
    endtask

    task automatic wait_arb(input int prev);
        int n;
        n = 0;
        while (n_arb == prev && n < 200) begin
            tick();
            n++;
        end
        chk("grant_timeout", 64'(n >= 200), 64'd0);
    endtask

    initial begin
        int prev;
        rst         = 1'b1;
        req         = '0;
        rand_en     = 1'b0;
        force_stuck = 1'b0;
        force_lat   = 0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i]  = '0;
            b_op[i]  = '0;
            rearm[i] = 0;
        end
        pack();
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;

        // Single request, negative multiplier.
        raise(0, 16'd3, 16'hFFFB);
        drain(200);

        // All four request from ptr 0; requester 0 re-requests once.
        do_reset();
        rearm[0] = 1;
        for (int i = 0; i < NREQ; i++) raise(i, 16'(i + 1), 16'd2);
        drain(400);

        // Fairness: req2 raised while op0 is in flight must be served before req0 again.
        do_reset();
        force_lat = 12;
        rearm[0]  = 1;
        prev      = n_arb;
        raise(0, 16'd7, 16'd9);
        wait_arb(prev);
        repeat (3) tick();
        raise(2, 16'hFFFC, 16'd5);
        drain(400);
        force_lat = 0;

        // Stuck multiplier, then a normal op.
        force_stuck = 1'b1;
        prev        = n_arb;
        raise(1, 16'd11, 16'd13);
        wait_arb(prev);
        force_stuck = 1'b0;
        drain(400);
        raise(1, 16'h1234, 16'hFF00);
        drain(200);

        // Reset mid-WAIT: ptr left at 3 beforehand, so a non-reset ptr would grant 3 first.
        raise(2, 16'd5, 16'd6);
        drain(200);
        force_lat = 15;
        prev      = n_arb;
        raise(1, 16'd100, 16'hFFF6);
        wait_arb(prev);
        repeat (4) tick();
        raise(3, 16'd21, 16'd2);
        do_reset();
        force_lat = 0;
        drain(400);

        // Operand extremes.
        raise(0, 16'h8000, 16'h8000);
        drain(200);
        raise(1, 16'h7FFF, 16'h8000);
        drain(200);

        // Randomized traffic.
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        drain(2000);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("start_queue_empty", 64'(st_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
